// File: rtl/regfile_2w2r_sb.sv
// Two-read / two-write register file with a pending-write scoreboard.
// Optional same-cycle write-to-read bypass: define RF_WRITE_BYPASS_EN.
module regfile_2w2r_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   input  logic [ADDR_W-1:0] rs1_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic              rs1_busy,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rs2_data,
   output logic              rs2_busy,
   input  logic              wa_en,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wa_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = '1;

   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic run;
   logic wa_we;
   logic wb_we;
   logic rsv_we;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   always_comb begin
      run    = (state_q == S_RUN);
      wa_we  = run && wa_en && !is_zero(wa_addr);
      wb_we  = run && wb_en && !is_zero(wb_addr);
      rsv_we = run && rsv_en && !is_zero(rsv_addr);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!run) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) state_d = S_RUN;
      end
   end

   // Set after clear so a same-cycle reserve keeps the entry busy.
   always_comb begin
      busy_d = busy_q;
      if (!run) begin
         busy_d = '0;
      end else begin
         if (wa_we)  busy_d[wa_addr]  = 1'b0;
         if (wb_we)  busy_d[wb_addr]  = 1'b0;
         if (rsv_we) busy_d[rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   // No reset on the array: the sweep clears it, port B lands last.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (!run) begin
            mem[cnt_q] <= '0;
         end else begin
            if (wa_we) mem[wa_addr] <= wa_data;
            if (wb_we) mem[wb_addr] <= wb_data;
         end
      end
   end

   assign ready = run;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              b;

      assign a = (p == 0) ? rs1_addr : rs2_addr;

      always_comb begin
         d = mem[a];
         b = busy_q[a];
`ifdef RF_WRITE_BYPASS_EN
         if (wb_we && (wb_addr == a)) begin
            d = wb_data;
         end else if (wa_we && (wa_addr == a)) begin
            d = wa_data;
         end
         if (((wa_we && (wa_addr == a)) || (wb_we && (wb_addr == a)))
             && !(rsv_we && (rsv_addr == a))) begin
            b = 1'b0;
         end
`endif
         if (!run || is_zero(a)) begin
            d = '0;
            b = 1'b0;
         end
      end
   end

   assign rs1_data = g_rd[0].d;
   assign rs1_busy = g_rd[0].b;
   assign rs2_data = g_rd[1].d;
   assign rs2_busy = g_rd[1].b;

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Scoreboard bench for regfile_2w2r_sb: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_regfile_2w2r_sb;

   localparam int DW = 32;
   localparam int AW = 5;

   localparam int K_RDY = 0;
   localparam int K_D1  = 1;
   localparam int K_B1  = 2;
   localparam int K_D2  = 3;
   localparam int K_B2  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ready;
   logic [AW-1:0] rs1_addr, rs2_addr;
   logic [DW-1:0] rs1_data, rs2_data;
   logic          rs1_busy, rs2_busy;
   logic          wa_en, wb_en, rsv_en;
   logic [AW-1:0] wa_addr, wb_addr, rsv_addr;
   logic [DW-1:0] wa_data, wb_data;

   regfile_2w2r_sb dut (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .rs1_addr (rs1_addr),
      .rs1_data (rs1_data),
      .rs1_busy (rs1_busy),
      .rs2_addr (rs2_addr),
      .rs2_data (rs2_data),
      .rs2_busy (rs2_busy),
      .wa_en    (wa_en),
      .wa_addr  (wa_addr),
      .wa_data  (wa_data),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   exp_t        e;
   logic [31:0] act;

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         case (e.kind)
            K_RDY:   act = {31'd0, ready};
            K_D1:    act = rs1_data;
            K_B1:    act = {31'd0, rs1_busy};
            K_D2:    act = rs2_data;
            default: act = {31'd0, rs2_busy};
         endcase
         checks++;
         if (act !== e.val) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     e.name, act, e.val, cyc);
         end
      end
   end

   task automatic want(input int kind, input logic [31:0] val,
                       input string name);
      q.push_back('{cyc, kind, val, name});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wa_en  = 1'b0;
      wb_en  = 1'b0;
      rsv_en = 1'b0;
   endtask

   task automatic init_check(input string tag);
      for (int i = 0; i < 32; i++) begin
         want(K_RDY, 32'd0, {tag, "_busy_sweep"});
         tick();
      end
      want(K_RDY, 32'd1, {tag, "_ready"});
   endtask

   initial begin
      rst      = 1'b0;
      rs1_addr = '0;
      rs2_addr = '0;
      wa_en = 1'b0; wa_addr = '0; wa_data = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      rsv_en = 1'b0; rsv_addr = '0;

      tick();
      want(K_RDY, 32'd0, "rst_ready");
      want(K_D1,  32'd0, "rst_rs1_data");
      want(K_D2,  32'd0, "rst_rs2_data");
      want(K_B1,  32'd0, "rst_rs1_busy");
      want(K_B2,  32'd0, "rst_rs2_busy");
      tick();
      tick();
      rst = 1'b1;
      init_check("init");

      for (int i = 0; i < 16; i++) begin
         rs1_addr = AW'(2 * i);
         rs2_addr = AW'(2 * i + 1);
         want(K_D1, 32'd0, "clr_rs1_data");
         want(K_D2, 32'd0, "clr_rs2_data");
         want(K_B1, 32'd0, "clr_rs1_busy");
         want(K_B2, 32'd0, "clr_rs2_busy");
         tick();
      end

      // dual write, port B wins
      rs1_addr = 5'd1;
      wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hAAAA_AAAA;
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h5555_5555;
      tick();
      idle();
      rs1_addr = 5'd5;
      want(K_D1, 32'h5555_5555, "dual_wr_b_wins");
      tick();

      // zero register
      rs1_addr = 5'd0;
      wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hDEAD_BEEF;
      rsv_en = 1'b1; rsv_addr = 5'd0;
      want(K_D1, 32'd0, "zero_data_same");
      want(K_B1, 32'd0, "zero_busy_same");
      tick();
      idle();
      want(K_D1, 32'd0, "zero_data_after");
      want(K_B1, 32'd0, "zero_busy_after");
      tick();

      // scoreboard: reserve r7, then write it
      rs2_addr = 5'd7;
      rsv_en = 1'b1; rsv_addr = 5'd7;
      want(K_B2, 32'd0, "rsv7_busy_same");
      tick();
      idle();
      want(K_B2, 32'd1, "rsv7_busy_set");
      wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h0000_1234;
`ifdef RF_WRITE_BYPASS_EN
      want(K_B2, 32'd0, "wr7_busy_same");
      want(K_D2, 32'h0000_1234, "wr7_data_same");
`else
      want(K_B2, 32'd1, "wr7_busy_same");
      want(K_D2, 32'd0, "wr7_data_same");
`endif
      tick();
      idle();
      want(K_B2, 32'd0, "wr7_busy_clr");
      want(K_D2, 32'h0000_1234, "wr7_data");
      tick();

      // reserve and write r9 together: set wins
      rs1_addr = 5'd9;
      rsv_en = 1'b1; rsv_addr = 5'd9;
      wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h0000_0099;
      want(K_B1, 32'd0, "rw9_busy_same");
`ifdef RF_WRITE_BYPASS_EN
      want(K_D1, 32'h0000_0099, "rw9_data_same");
`else
      want(K_D1, 32'd0, "rw9_data_same");
`endif
      tick();
      idle();
      want(K_B1, 32'd1, "rw9_busy_set");
      want(K_D1, 32'h0000_0099, "rw9_data");
      rsv_en = 1'b1; rsv_addr = 5'd9;
      tick();
      idle();
      want(K_B1, 32'd1, "rsv9_again");
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_00AB;
      tick();
      idle();
      want(K_B1, 32'd0, "wb9_busy_clr");
      want(K_D1, 32'h0000_00AB, "wb9_data");
      tick();

      // bypass / visibility timing on r3
      rs1_addr = 5'd2;
      wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h0000_1111;
      tick();
      idle();
      rs1_addr = 5'd3;
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0F0F;
`ifdef RF_WRITE_BYPASS_EN
      want(K_D1, 32'h0000_0F0F, "byp3_same");
`else
      want(K_D1, 32'h0000_1111, "byp3_same");
`endif
      tick();
      idle();
      want(K_D1, 32'h0000_0F0F, "byp3_next");
      tick();

      // double match on r6: port B has priority
      rs2_addr = 5'd6;
      wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'h0000_A6A6;
      wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000_B6B6;
`ifdef RF_WRITE_BYPASS_EN
      want(K_D2, 32'h0000_B6B6, "byp6_same");
`else
      want(K_D2, 32'd0, "byp6_same");
`endif
      tick();
      idle();
      want(K_D2, 32'h0000_B6B6, "wr6_next");
      tick();

      // reset during RUN, then a second pulse mid-sweep
      rs1_addr = 5'd4;
      wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h0000_0077;
      tick();
      idle();
      rsv_en = 1'b1; rsv_addr = 5'd4;
      tick();
      idle();
      want(K_D1, 32'h0000_0077, "r4_data_pre");
      want(K_B1, 32'd1, "r4_busy_pre");
      rst = 1'b0;
      tick();
      rst = 1'b1;
      want(K_RDY, 32'd0, "rst_run_drop");
      want(K_B1, 32'd0, "rst_run_busy");
      for (int i = 0; i < 10; i++) tick();
      want(K_RDY, 32'd0, "mid_sweep");
      rst = 1'b0;
      tick();
      rst = 1'b1;
      init_check("reinit");
      want(K_D1, 32'd0, "r4_data_post");
      want(K_B1, 32'd0, "r4_busy_post");
      tick();

      for (int i = 0; i < 5 && q.size() > 0; i++) tick();
      if (q.size() > 0) begin
         $display("FAIL drain: got %0d pending want 0", q.size());
         errors += q.size();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
- Parametrised successor register file for the core: 2 read ports, 2 write ports, and a per-register pending-write scoreboard.
- Storage is cleared by a post-reset init sweep (one entry per cycle), so the array can map onto RAM-style storage.
- Sits between decode (read/reserve) and writeback.
- Issue logic uses the busy outputs to stall on pending writes.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 hardwired to zero (never written, never busy); 0 = entry 0 is an ordinary register

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
ready  output  1  1 = init sweep done, ports live
rs1_addr  input  ADDR_W  read port 1 address
rs1_data  output  DATA_W  read port 1 data (combinational)
rs1_busy  output  1  scoreboard bit of rs1_addr
rs2_addr  input  ADDR_W  read port 2 address
rs2_data  output  DATA_W  read port 2 data (combinational)
rs2_busy  output  1  scoreboard bit of rs2_addr
wa_en  input  1  write port A enable
wa_addr  input  ADDR_W  write port A address
wa_data  input  DATA_W  write port A data
wb_en  input  1  write port B enable
wb_addr  input  ADDR_W  write port B address
wb_data  input  DATA_W  write port B data
rsv_en  input  1  reserve (mark busy) enable
rsv_addr  input  ADDR_W  entry to reserve

Behaviour:
- Two states: INIT and RUN. rst=0 at a rising edge forces INIT, sweep counter=0, all scoreboard bits=0. This applies from any state, including mid-sweep.
- INIT:
  - Each cycle writes 0 to entry[counter], then increments the counter.
  - After the cycle that clears entry DEPTH-1, state becomes RUN. Sweep = DEPTH cycles after rst returns to 1.
  - In INIT: ready=0, rs*_data=0, rs*_busy=0; writes and reserves are ignored.
- RUN: ready=1.
- Reset values: ready=0, rs1_data/rs2_data=0, rs1_busy/rs2_busy=0.
- Writes:
  - Port A and port B each write on the rising edge when enabled.
  - Both enabled to the same address: port B wins; port A is dropped.
  - ZERO_REG=1: writes to address 0 are ignored on both ports.
- Reads:
  - Combinational from the array, or the forwarded value (see optional feature).
  - ZERO_REG=1 and address 0: data=0 and busy=0 regardless of other state.
- Scoreboard (RUN only):
  - An enabled write to address X clears busy[X] at the edge.
  - rsv_en sets busy[rsv_addr] at the edge.
  - Same-cycle reserve and write to the same X: set wins (busy[X]=1 after the edge, data still written).
  - Reserving an already-busy entry leaves it busy; no counting or nesting.
- rs*_busy reflects the registered scoreboard bits, not the same-cycle write/reserve.
- No backpressure: the block never refuses a write. Stall decisions belong to the issuer.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: a read whose address matches an enabled same-cycle write returns that write's data, combinationally.
  - Port B has priority over port A on a double match.
  - Address-0 rule (ZERO_REG=1) still applies.
  - rs*_busy is also forced 0 when the matching write clears that entry and no same-cycle reserve hits it.
- Undefined: reads return array contents only; a written value is visible from the cycle after the write edge. Busy outputs are purely registered.

Test Plan:
- Init timing: hold rst=0 for 3 cycles, release → ready=0 for exactly 32 cycles (defaults), then 1. All 32 entries read 0 and all busy=0.
- Dual write conflict: wa_en=wb_en=1, wa_addr=wb_addr=5, wa_data=0xAAAA_AAAA, wb_data=0x5555_5555 → next cycle rs1_addr=5 reads 0x5555_5555.
- Zero register: wa writes 0xDEADBEEF to addr 0, and rsv_en=1 with rsv_addr=0 → rs1_data=0 and rs1_busy=0 afterwards (ZERO_REG=1).
- Scoreboard: reserve r7 → rs2_busy=1 next cycle. Write r7=0x1234 via port A → busy=0 next cycle, data 0x1234. Reserve and write r9 in the same cycle → busy[9]=1, data written.
- Bypass: with RF_WRITE_BYPASS_EN, wb writes r3=0x0F0F while rs1_addr=3 → rs1_data=0x0F0F in the same cycle. Without the macro → old value this cycle, 0x0F0F next cycle.
- Reset mid-operation: busy on r4, entry r4=0x77, rst=0 for 1 cycle during RUN → ready drops. After the sweep, r4 reads 0 and busy=0. A second rst pulse mid-sweep restarts the 32-cycle count.
